regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter AW, default 5, register address width; SHALL satisfy 2**AW >= NREG.
REQ-003 SHALL have parameter DW, default 32, register data width.
REQ-004 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rd_addr  input  NRD*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRD*DW  packed read data, port k at [k*DW +: DW].
REQ-010 SHALL have port rd_busy  output  NRD  per-port pending-write flag.
REQ-011 SHALL have ports wr0_en/wr0_addr/wr0_data  input  1/AW/DW  write port 0.
REQ-012 SHALL have ports wr1_en/wr1_addr/wr1_data  input  1/AW/DW  write port 1 (higher priority).
REQ-013 SHALL have ports iss_en/iss_addr  input  1/AW  issue: mark destination register pending.
REQ-014 SHALL have port flush  input  1  clear all pending marks.
REQ-015 SHALL have port busy_vec  output  NREG  registered scoreboard state.

Function
REQ-016 SHALL write wrN_data into register wrN_addr on the rising clk edge when wrN_en=1.
REQ-017 SHALL, when both write ports target the same address in one cycle, store wr1_data only.
REQ-018 SHALL ignore writes to register 0 when ZERO_REG=1; SHALL ignore addresses >= NREG.
REQ-019 SHALL produce rd_data combinationally (zero latency) with bypass priority: wr1 match, then wr0 match, then stored value.
REQ-020 SHALL return 0 for address 0 when ZERO_REG=1 regardless of writes or bypass; 0 for addresses >= NREG.
REQ-021 SHALL set busy_vec[iss_addr] on the rising edge when iss_en=1 (not for register 0 when ZERO_REG=1).
REQ-022 SHALL clear busy_vec[a] on the rising edge when either write port writes address a.
REQ-023 SHALL, for simultaneous issue and write to the same address, leave the bit set (issue wins).
REQ-024 SHALL clear all busy_vec bits on the rising edge when flush=1, overriding any same-cycle issue.
REQ-025 SHALL drive rd_busy[k] = busy_vec[rd_addr k] AND NOT (same-cycle enabled write to that address).
REQ-026 SHALL keep register contents unchanged on flush.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear all registers and busy_vec to 0; rd_data and rd_busy then read 0.
REQ-028 SHALL abandon any same-cycle write or issue asserted while rst_n low; resume normally on first rising edge after release.

Structure
REQ-029 SHALL place shared defaults (NREG, AW, DW) and the packed-port index helper in package rv32_pkg.
REQ-030 SHALL implement the busy-bit logic in sub-module regfile_scoreboard (issue, two clear ports, flush, busy_vec).

Verification
REQ-031 SHALL check: reset, then read x5 and x0 -> both 0, rd_busy 0, busy_vec 0.
REQ-032 SHALL check: wr0 x3=0xA5A5_0001 and wr1 x3=0x1234_5678 same cycle -> rd_data(x3) 0x1234_5678 during that cycle and after.
REQ-033 SHALL check: write x0=0xFFFF_FFFF with ZERO_REG=1 -> x0 reads 0, busy_vec[0] stays 0 after issue to x0.
REQ-034 SHALL check: iss x7, next cycle wr0 x7=0x42 -> rd_busy 1 before, 0 in write cycle with rd_data 0x42 bypassed, busy_vec[7] 0 after.
REQ-035 SHALL check: iss x9 and wr1 x9 same cycle -> busy_vec[9]=1 next cycle; flush with iss x10 -> busy_vec all 0.
REQ-036 SHALL check: NRD=4, all ports read x1..x4 after writes 1..4 -> each port returns its value.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared register-file defaults and the packed-port slice helper.
// Latency: n/a (compile-time constants and a pure function only).
// Backpressure: none; nothing in this package holds state.
package rv32_pkg;

  localparam int RV_NREG = 32;
  localparam int RV_AW   = 5;
  localparam int RV_DW   = 32;

  // Low bit of lane k in a bus of equal-width lanes of width w.
  function automatic int pk_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Latency: issue/clear/flush take effect on the next rising edge.
// Backpressure: none; every request is accepted in the cycle it is presented.
module regfile_scoreboard
  import rv32_pkg::*;
#(
  parameter int NREG     = RV_NREG,
  parameter int AW       = RV_AW,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_iss_en,
  input  logic [AW-1:0]   i_iss_addr,
  input  logic            i_clr0_en,
  input  logic [AW-1:0]   i_clr0_addr,
  input  logic            i_clr1_en,
  input  logic [AW-1:0]   i_clr1_addr,
  input  logic            i_flush,
  output logic [NREG-1:0] o_busy_vec
);

  logic [NREG-1:0] r_busy;

  // Per-bit update: flush beats everything, issue beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_iss_en && (i_iss_addr == AW'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
          r_busy[i] <= 1'b1;
        end else if ((i_clr0_en && (i_clr0_addr == AW'(i))) ||
                     (i_clr1_en && (i_clr1_addr == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with write bypass and pending-write scoreboard.
// Latency: reads are combinational (zero cycles); writes/issue land on the next rising edge.
// Backpressure: none; rd_busy only reports a pending producer, it never stalls the file.
module regfile_sb
  import rv32_pkg::*;
#(
  parameter int NREG     = RV_NREG,
  parameter int AW       = RV_AW,
  parameter int DW       = RV_DW,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec
);

  logic [DW-1:0]   r_regs [NREG];
  logic [NREG-1:0] w_busy_vec;

  // Storage update: wr1 wins an address collision; register 0 stays zero when hardwired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!((ZERO_REG != 0) && (i == 0))) begin
          if (wr1_en && (wr1_addr == AW'(i))) begin
            r_regs[i] <= wr1_data;
          end else if (wr0_en && (wr0_addr == AW'(i))) begin
            r_regs[i] <= wr0_data;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_iss_en    (iss_en),
    .i_iss_addr  (iss_addr),
    .i_clr0_en   (wr0_en),
    .i_clr0_addr (wr0_addr),
    .i_clr1_en   (wr1_en),
    .i_clr1_addr (wr1_addr),
    .i_flush     (flush),
    .o_busy_vec  (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    localparam int LA = pk_lo(k, AW);
    localparam int LD = pk_lo(k, DW);

    logic [AW-1:0] w_addr;
    logic          w_valid;
    logic          w_hit0;
    logic          w_hit1;
    logic [DW-1:0] w_data;

    assign w_addr  = rd_addr[LA +: AW];
    // Out-of-range and hardwired-zero addresses never see bypass or busy.
    assign w_valid = (int'(w_addr) < NREG) && !((ZERO_REG != 0) && (w_addr == '0));
    assign w_hit1  = wr1_en && (wr1_addr == w_addr);
    assign w_hit0  = wr0_en && (wr0_addr == w_addr);

    // Read mux: wr1 bypass, then wr0 bypass, then stored value.
    always_comb begin
      w_data = '0;
      if (w_valid) begin
        if (w_hit1) begin
          w_data = wr1_data;
        end else if (w_hit0) begin
          w_data = wr0_data;
        end else begin
          w_data = r_regs[w_addr];
        end
      end
    end

    assign rd_data[LD +: DW] = w_data;
    // A producer writing this cycle is no longer pending from the reader's view.
    assign rd_busy[k] = w_valid && w_busy_vec[w_addr] && !w_hit0 && !w_hit1;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb (4 read ports): table of cycle vectors plus reset sequences.
// Latency: expected values are queued when a vector is driven and popped mid-cycle.
// Backpressure: none.
module tb_regfile_sb;

  logic         clk;
  logic         rst_n;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic         wr0_en;
  logic [4:0]   wr0_addr;
  logic [31:0]  wr0_data;
  logic         wr1_en;
  logic [4:0]   wr1_addr;
  logic [31:0]  wr1_data;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic         flush;
  logic [31:0]  busy_vec;

  regfile_sb #(
    .NREG     (32),
    .AW       (5),
    .DW       (32),
    .NRD      (4),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         w0e;
    logic [4:0]   w0a;
    logic [31:0]  w0d;
    logic         w1e;
    logic [4:0]   w1a;
    logic [31:0]  w1d;
    logic         ie;
    logic [4:0]   ia;
    logic         fl;
    logic [19:0]  ra;
    logic [127:0] ed;
    logic [3:0]   eb;
    logic [31:0]  ebv;
  } vec_t;

  typedef struct {
    logic [127:0] rd;
    logic [3:0]   bsy;
    logic [31:0]  bv;
  } exp_t;

  vec_t vecs [15];
  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
    input logic ie, input logic [4:0] ia, input logic fl,
    input logic [19:0] ra, input logic [127:0] ed, input logic [3:0] eb,
    input logic [31:0] ebv);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ie = ie; v.ia = ia; v.fl = fl;
    v.ra = ra; v.ed = ed; v.eb = eb; v.ebv = ebv;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic set_idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
    wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
    iss_en = v.ie;  iss_addr = v.ia;  flush = v.fl;
    rd_addr = v.ra;
  endtask

  initial begin
    exp_t e;
    // Read ports packed {p3,p2,p1,p0}; busy_vec is the state before this cycle's edge.
    vecs[0]  = mk(0,0,0, 0,0,0, 0,0,0, {5'd0,5'd5,5'd0,5'd5},
                  {32'h0,32'h0,32'h0,32'h0}, 4'b0000, 32'h0);
    vecs[1]  = mk(1,3,32'hA5A5_0001, 1,3,32'h1234_5678, 0,0,0, {5'd1,5'd0,5'd3,5'd3},
                  {32'h0,32'h0,32'h1234_5678,32'h1234_5678}, 4'b0000, 32'h0);
    vecs[2]  = mk(0,0,0, 0,0,0, 0,0,0, {5'd1,5'd0,5'd3,5'd3},
                  {32'h0,32'h0,32'h1234_5678,32'h1234_5678}, 4'b0000, 32'h0);
    vecs[3]  = mk(1,0,32'hFFFF_FFFF, 0,0,0, 1,0,0, {5'd0,5'd0,5'd3,5'd0},
                  {32'h0,32'h0,32'h1234_5678,32'h0}, 4'b0000, 32'h0);
    vecs[4]  = mk(0,0,0, 0,0,0, 1,7,0, {5'd0,5'd3,5'd7,5'd0},
                  {32'h0,32'h1234_5678,32'h0,32'h0}, 4'b0000, 32'h0);
    vecs[5]  = mk(0,0,0, 0,0,0, 0,0,0, {5'd0,5'd3,5'd7,5'd0},
                  {32'h0,32'h1234_5678,32'h0,32'h0}, 4'b0010, 32'h0000_0080);
    vecs[6]  = mk(1,7,32'h42, 0,0,0, 0,0,0, {5'd3,5'd0,5'd7,5'd7},
                  {32'h1234_5678,32'h0,32'h42,32'h42}, 4'b0000, 32'h0000_0080);
    vecs[7]  = mk(0,0,0, 0,0,0, 0,0,0, {5'd7,5'd7,5'd7,5'd7},
                  {32'h42,32'h42,32'h42,32'h42}, 4'b0000, 32'h0);
    vecs[8]  = mk(0,0,0, 1,9,32'h99, 1,9,0, {5'd0,5'd9,5'd7,5'd9},
                  {32'h0,32'h99,32'h42,32'h99}, 4'b0000, 32'h0);
    vecs[9]  = mk(0,0,0, 0,0,0, 0,0,0, {5'd9,5'd9,5'd9,5'd9},
                  {32'h99,32'h99,32'h99,32'h99}, 4'b1111, 32'h0000_0200);
    vecs[10] = mk(0,0,0, 0,0,0, 1,10,1, {5'd3,5'd7,5'd10,5'd9},
                  {32'h1234_5678,32'h42,32'h0,32'h99}, 4'b0001, 32'h0000_0200);
    vecs[11] = mk(0,0,0, 0,0,0, 0,0,0, {5'd3,5'd7,5'd10,5'd9},
                  {32'h1234_5678,32'h42,32'h0,32'h99}, 4'b0000, 32'h0);
    vecs[12] = mk(1,1,32'h1, 1,2,32'h2, 0,0,0, {5'd4,5'd3,5'd2,5'd1},
                  {32'h0,32'h1234_5678,32'h2,32'h1}, 4'b0000, 32'h0);
    vecs[13] = mk(1,3,32'h3, 1,4,32'h4, 0,0,0, {5'd4,5'd3,5'd2,5'd1},
                  {32'h4,32'h3,32'h2,32'h1}, 4'b0000, 32'h0);
    vecs[14] = mk(0,0,0, 0,0,0, 0,0,0, {5'd4,5'd3,5'd2,5'd1},
                  {32'h4,32'h3,32'h2,32'h1}, 4'b0000, 32'h0);

    // Power-on reset with idle inputs: everything reads zero.
    set_idle();
    rst_n   = 1'b0;
    rd_addr = {5'd0, 5'd5, 5'd0, 5'd5};
    #3;
    check("rst_rd_data", rd_data, 128'h0);
    check("rst_rd_busy", {124'h0, rd_busy}, 128'h0);
    check("rst_busy_vec", {96'h0, busy_vec}, 128'h0);

    // Write and issue held across an edge while in reset must be dropped.
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    iss_en = 1'b1; iss_addr = 5'd5;
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      exp_q.push_back('{rd: vecs[i].ed, bsy: vecs[i].eb, bv: vecs[i].ebv});
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_rd_data", i), rd_data, e.rd);
      check($sformatf("v%0d_rd_busy", i), {124'h0, rd_busy}, {124'h0, e.bsy});
      check($sformatf("v%0d_busy_vec", i), {96'h0, busy_vec}, {96'h0, e.bv});
      @(posedge clk); #1;
    end
    set_idle();

    // Mid-run asynchronous reset clears contents and busy bits without a clock edge.
    iss_en = 1'b1; iss_addr = 5'd12;
    rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    check("pre_arst_busy_vec", {96'h0, busy_vec}, {96'h0, 32'h0000_1000});
    check("pre_arst_rd_data", rd_data, {32'h4, 32'h3, 32'h2, 32'h1});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy_vec", {96'h0, busy_vec}, 128'h0);
    check("arst_rd_data", rd_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_arst_rd_data", rd_data, 128'h0);
    check("post_arst_rd_busy", {124'h0, rd_busy}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
